// File: rtl/exc_ctrl.sv
// ----------------------------------------------------------------------------
// exc_ctrl
//
// Exception / ERET sequencing controller sitting between write-back, CP0 and
// fetch. When the instruction in WB raises an interrupt, an exception or is
// an ERET, the controller cancels its register-file write, issues one commit
// strobe to CP0, holds a pipeline-wide flush for FLUSH_CYCLES extra cycles and
// then hands the redirect PC to fetch through a valid/ready handshake.
//
// Parameters
//   EXC_ENTRY     exception vector PC
//   FLUSH_CYCLES  cycles flush is held after the commit cycle (0 allowed)
//
// Ports
//   clk, resetn        clock, asynchronous active-low reset
//   ws_valid           WB holds a valid instruction
//   ws_exc/ws_exccode  WB synchronous exception and its ExcCode
//   ws_eret            WB instruction is ERET
//   ws_bd              WB instruction sits in a branch delay slot
//   ws_pc/ws_badvaddr  WB PC and faulting address
//   int_pending        enabled, unmasked interrupt from CP0
//   cp0_epc            current CP0 EPC (ERET target)
//   ws_cancel          combinational WB write suppress
//   exc_commit         one-cycle strobe, CP0 takes exc_code/epc/bd/badvaddr
//   exc_code/exc_epc/exc_bd/exc_badvaddr  last latched exception record
//   eret_commit        one-cycle strobe, CP0 clears EXL
//   flush              flush all pipeline stages
//   redirect_valid/redirect_pc/redirect_ready  redirect handshake to fetch
//   busy               controller is not idle
// ----------------------------------------------------------------------------
module exc_ctrl #(
  parameter logic [31:0] EXC_ENTRY    = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        ws_valid,
  input  logic        ws_exc,
  input  logic [4:0]  ws_exccode,
  input  logic        ws_eret,
  input  logic        ws_bd,
  input  logic [31:0] ws_pc,
  input  logic [31:0] ws_badvaddr,
  input  logic        int_pending,
  input  logic [31:0] cp0_epc,
  output logic        ws_cancel,
  output logic        exc_commit,
  output logic [4:0]  exc_code,
  output logic [31:0] exc_epc,
  output logic        exc_bd,
  output logic [31:0] exc_badvaddr,
  output logic        eret_commit,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
);

  // Counter only needs to hold FLUSH_CYCLES; keep at least one bit so the
  // FLUSH_CYCLES=0 build still has a legal (unused) register.
  localparam int unsigned CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    FLUSH    = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic is_idle;
  logic trap_p0;
  logic evt_p0;

  // EPC points at the branch when the faulting instruction is in its delay
  // slot; the subtraction wraps modulo 2^32 on purpose.
  function automatic logic [31:0] epc_of(input logic bd, input logic [31:0] pc);
    return bd ? (pc - 32'd4) : pc;
  endfunction

  // Stage p0: event detection on the WB instruction (combinational).
  // Interrupts and exceptions cancel the write-back; ERET does not.
  assign is_idle   = (state == IDLE);
  assign trap_p0   = ws_valid & (int_pending | ws_exc);
  assign evt_p0    = is_idle & ws_valid & (int_pending | ws_exc | ws_eret);
  assign ws_cancel = is_idle & trap_p0;

  // Stage p1: sequencing FSM, all outputs registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      cnt            <= '0;
      exc_commit     <= 1'b0;
      eret_commit    <= 1'b0;
      exc_code       <= 5'd0;
      exc_epc        <= 32'd0;
      exc_bd         <= 1'b0;
      exc_badvaddr   <= 32'd0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
      busy           <= 1'b0;
    end else begin
      // Commit strobes are single-cycle: they only survive the COMMIT cycle.
      exc_commit  <= 1'b0;
      eret_commit <= 1'b0;
      case (state)
        IDLE: begin
          if (evt_p0) begin
            state        <= COMMIT;
            busy         <= 1'b1;
            flush        <= 1'b1;
            exc_commit   <= trap_p0;
            eret_commit  <= ~trap_p0;
            exc_code     <= int_pending ? 5'd0 : ws_exccode;
            exc_epc      <= epc_of(ws_bd, ws_pc);
            exc_bd       <= ws_bd;
            exc_badvaddr <= ws_badvaddr;
            redirect_pc  <= trap_p0 ? EXC_ENTRY : cp0_epc;
          end
        end
        COMMIT: begin
          if (FLUSH_CYCLES > 0) begin
            state <= FLUSH;
            cnt   <= CNT_LOAD;
          end else begin
            state          <= REDIRECT;
            flush          <= 1'b0;
            redirect_valid <= 1'b1;
          end
        end
        FLUSH: begin
          if (cnt == CNT_ONE) begin
            state          <= REDIRECT;
            cnt            <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state          <= IDLE;
            redirect_valid <= 1'b0;
            busy           <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception/ERET sequencing controller between the write-back stage, the CP0 register block and the fetch stage. Detects an interrupt, exception or ERET on the instruction in WB and cancels that instruction's write-back. It then issues a single commit strobe to CP0, holds a pipeline-wide flush for a programmable number of cycles, and delivers the redirect PC to fetch through a valid/ready handshake.

## Interface
- EXC_ENTRY, 32'hBFC0_0380, exception vector PC
- FLUSH_CYCLES, 2, cycles flush is held after the commit cycle (0 allowed)
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- ws_valid  in  1  WB holds a valid instruction
- ws_exc  in  1  WB instruction carries a synchronous exception
- ws_exccode  in  5  ExcCode of that exception
- ws_eret  in  1  WB instruction is ERET
- ws_bd  in  1  WB instruction is in a branch delay slot
- ws_pc  in  32  WB instruction PC
- ws_badvaddr  in  32  faulting address
- int_pending  in  1  CP0 reports an enabled, unmasked interrupt (CP0 already masks by EXL/IE)
- cp0_epc  in  32  current CP0 EPC
- ws_cancel  out  1  combinational; suppress WB register-file write this cycle
- exc_commit  out  1  one-cycle strobe; CP0 updates Cause/EPC/BadVAddr/EXL
- exc_code  out  5  committed ExcCode
- exc_epc  out  32  committed EPC
- exc_bd  out  1  committed BD bit
- exc_badvaddr  out  32  committed bad address
- eret_commit  out  1  one-cycle strobe; CP0 clears EXL
- flush  out  1  flush all pipeline stages
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  redirect target
- redirect_ready  in  1  fetch accepts redirect
- busy  out  1  state != IDLE

## Operation
- States: IDLE, COMMIT, FLUSH, REDIRECT.
- Event in IDLE: ws_valid & (int_pending | ws_exc | ws_eret). Priority: int_pending (code 0) > ws_exc (ws_exccode) > ws_eret.
- ws_cancel = (state==IDLE) & ws_valid & (int_pending | ws_exc). It is 0 for ERET and 0 outside IDLE.
- On an event, the following are latched:
  - kind (exc/eret) and code.
  - epc = ws_bd ? ws_pc - 32'd4 : ws_pc (mod 2^32).
  - bd and badvaddr.
  - target = exc ? EXC_ENTRY : cp0_epc.
- The FSM then moves to COMMIT.
- COMMIT (one cycle):
  - Drives flush=1.
  - Drives exc_commit=1 for an exception/interrupt, or eret_commit=1 for ERET (exactly one of the two).
  - Next state is FLUSH if FLUSH_CYCLES>0, else REDIRECT.
- FLUSH: flush=1. A down-counter, loaded with FLUSH_CYCLES on entry, decrements each cycle; the FSM leaves for REDIRECT when the counter reaches 1.
- REDIRECT:
  - Drives redirect_valid=1 with redirect_pc=target, both stable.
  - On redirect_valid & redirect_ready the FSM returns to IDLE.
  - flush=0 in this state.
- All ws_* and int_pending inputs are ignored outside IDLE; at most one commit occurs per event.
- exc_code/exc_epc/exc_bd/exc_badvaddr hold the last latched values and are valid whenever exc_commit=1.

## Timing
- resetn low: asynchronously forces IDLE and drives all outputs and registers to 0, including exc_epc, redirect_pc and the counter. ws_cancel stays purely combinational.
- Reset asserted mid-sequence aborts it immediately; no commit or redirect follows its release.
- Event detected at cycle T:
  - ws_cancel is asserted in T.
  - The commit strobe fires at T+1.
  - flush is high over T+1 .. T+1+FLUSH_CYCLES.
  - redirect_valid rises at T+2+FLUSH_CYCLES (T+4 at the default).
- redirect_valid is held until accepted; the transfer occurs in the cycle where ready=1. The earliest next event is accepted in the cycle after the transfer.
- If redirect_ready is already high on the first REDIRECT cycle, the redirect completes in one cycle.

## Test plan
- Syscall: ws_exc=1, code 8, pc 0xBFC0_0100, bd=0 at T, ready=1.
  - ws_cancel=1 at T.
  - exc_commit at T+1 with code 8, epc 0xBFC0_0100.
  - flush over T+1..T+3.
  - redirect_valid at T+4 with pc 0xBFC0_0380; busy=0 at T+5.
- Delay slot wrap: bd=1, pc 0x0000_0000 -> exc_epc 0xFFFF_FFFC, exc_bd=1.
- ERET: ws_eret=1, cp0_epc 0x8000_1234, redirect_ready low for 3 cycles.
  - eret_commit at T+1 and no exc_commit; ws_cancel=0.
  - redirect_valid held with pc 0x8000_1234 stable until ready, then IDLE.
- Priority: int_pending, ws_exc (code 4) and ws_eret all set, pc 0x80 -> exc_commit only, code 0, epc 0x80, target 0xBFC0_0380.
- Ignored events: ws_exc pulsed during FLUSH and REDIRECT -> no second commit; ws_cancel=0; a single redirect.
- FLUSH_CYCLES=0: flush only at T+1, redirect_valid at T+2. resetn low during FLUSH -> all outputs 0 immediately; after release the FSM is IDLE and no redirect occurs.
